// File: rtl/rs_sched_pkg.sv
// Shared scheduler definitions: default sizing constants and index/latency
// typedefs used by the reservation-station blocks.
package rs_sched_pkg;

  localparam int NUM_OF_RS_DEF    = 8;
  localparam int NUM_OF_FU_DEF    = 2;
  localparam int LAT_WIDTH_DEF    = 4;
  localparam int RS_IDX_WIDTH_DEF = $clog2(NUM_OF_RS_DEF);
  localparam int FU_IDX_WIDTH_DEF = (NUM_OF_FU_DEF <= 1) ? 1 : $clog2(NUM_OF_FU_DEF);

  typedef logic [RS_IDX_WIDTH_DEF-1:0] rs_idx_t;
  typedef logic [FU_IDX_WIDTH_DEF-1:0] fu_idx_t;
  typedef logic [LAT_WIDTH_DEF-1:0]    lat_t;

endpackage

// File: rtl/rs_rr_first_set.sv
// Finds the first set request bit at or after a start pointer, wrapping
// from the top index back to 0.
module rs_rr_first_set #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int          pos;
    logic [IW-1:0] pidx;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    pidx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      pidx = IW'(pos);
      if (req_i[pidx]) begin
        found_o = 1'b1;
        idx_o   = pidx;
      end
    end
  end

endmodule

// File: rtl/rs_fu_issue_ctrl.sv
// Issue controller: matches eligible RS entries to free FUs with a
// round-robin start pointer, tracks FU occupancy and masks entries for
// the cycle after they issue.
module rs_fu_issue_ctrl
  import rs_sched_pkg::*;
#(
  parameter int NUM_OF_RS    = NUM_OF_RS_DEF,
  parameter int NUM_OF_FU    = NUM_OF_FU_DEF,
  parameter int LAT_WIDTH    = LAT_WIDTH_DEF,
  parameter int RS_IDX_WIDTH = $clog2(NUM_OF_RS),
  parameter int FU_IDX_WIDTH = (NUM_OF_FU <= 1) ? 1 : $clog2(NUM_OF_FU)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_OF_RS-1:0]              rs_ready,
  input  logic [LAT_WIDTH*NUM_OF_RS-1:0]    rs_latency,
  input  logic [NUM_OF_FU-1:0]              fu_stall,
  output logic [NUM_OF_RS-1:0]              rs_dispatch_en,
  output logic [FU_IDX_WIDTH*NUM_OF_RS-1:0] rs_fu_assign,
  output logic [NUM_OF_FU-1:0]              issue_valid,
  output logic [RS_IDX_WIDTH*NUM_OF_FU-1:0] issue_rs_idx,
  output logic [NUM_OF_FU-1:0]              fu_busy
);

  logic [RS_IDX_WIDTH-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NUM_OF_RS-1:0]                    issued_mask_q;
  logic [NUM_OF_FU-1:0][LAT_WIDTH-1:0]     busy_cnt_q;

  logic [NUM_OF_RS-1:0][LAT_WIDTH-1:0]     lat_arr;
  logic [NUM_OF_RS-1:0]                    eligible;
  logic [NUM_OF_FU-1:0][NUM_OF_RS-1:0]     avail;
  logic [NUM_OF_FU-1:0][NUM_OF_RS-1:0]     take;
  logic [NUM_OF_FU-1:0]                    found;
  logic [NUM_OF_FU-1:0]                    grant;
  logic [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0]  sel_idx;
  logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0]  assign_d;
  logic [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0]  issue_idx_d;

  assign lat_arr  = rs_latency;
  assign eligible = rs_ready & ~issued_mask_q;

  // One search stage per FU; each stage only sees entries the lower FUs left.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OF_FU; gi++) begin : g_fu
      if (gi == 0) begin : g_first
        assign avail[gi] = eligible;
      end else begin : g_rest
        assign avail[gi] = avail[gi-1] & ~take[gi-1];
      end

      rs_rr_first_set #(
        .N  (NUM_OF_RS),
        .IW (RS_IDX_WIDTH)
      ) u_find (
        .req_i   (avail[gi]),
        .start_i (rr_ptr_q),
        .found_o (found[gi]),
        .idx_o   (sel_idx[gi])
      );

      // Grants are suppressed entirely during reset and flush.
      assign grant[gi]   = found[gi] && (busy_cnt_q[gi] == '0) && !fu_stall[gi] && !rst && !flush;
      assign take[gi]    = grant[gi] ? (NUM_OF_RS'(1) << sel_idx[gi]) : '0;
      assign fu_busy[gi] = (busy_cnt_q[gi] != '0);

      // Occupancy counter: load latency-1 on grant, otherwise count down to 0.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          busy_cnt_q[gi] <= '0;
        end else if (grant[gi]) begin
          busy_cnt_q[gi] <= (lat_arr[sel_idx[gi]] == '0) ? '0 : lat_arr[sel_idx[gi]] - 1'b1;
        end else if (busy_cnt_q[gi] != '0) begin
          busy_cnt_q[gi] <= busy_cnt_q[gi] - 1'b1;
        end
      end
    end
  endgenerate

  // Fan grants out to per-entry and per-FU views; last granted FU sets the pointer.
  always_comb begin
    rs_dispatch_en = '0;
    assign_d       = '0;
    issue_idx_d    = '0;
    rr_ptr_d       = rr_ptr_q;
    for (int f = 0; f < NUM_OF_FU; f++) begin
      rs_dispatch_en = rs_dispatch_en | take[f];
      if (grant[f]) begin
        assign_d[sel_idx[f]] = FU_IDX_WIDTH'(f);
        issue_idx_d[f]       = sel_idx[f];
        rr_ptr_d = (sel_idx[f] == RS_IDX_WIDTH'(NUM_OF_RS - 1)) ? '0 : sel_idx[f] + 1'b1;
      end
    end
  end

  assign issue_valid  = grant;
  assign rs_fu_assign = assign_d;
  assign issue_rs_idx = issue_idx_d;

  // Pointer and just-issued mask; flush clears the mask but keeps fairness state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      issued_mask_q <= '0;
    end else if (flush) begin
      issued_mask_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issued_mask_q <= rs_dispatch_en;
    end
  end

endmodule
